// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: owns the PC, fetches from a combinational instruction memory,
// and buffers {pc, word} in a small FIFO toward decode. `define FETCH_PERF_EN adds perf counters.
module fetch_sequencer #(
  parameter logic [63:0] RESET_PC   = 64'd0,
  parameter int unsigned MEM_BYTES  = 16,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic [63:0] Inst_Address,
  input  logic [31:0] Instruction,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  input  logic        halt,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instruction,
  output logic [63:0] out_pc,
  output logic        fault,
  output logic [63:0] fault_pc
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stalled
`endif
);

  localparam int unsigned      PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned      CNT_W     = $clog2(FIFO_DEPTH + 1);
  localparam logic [63:0]      LAST_ADDR = 64'(MEM_BYTES) - 64'd4;
  localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    RUN,
    HALTED,
    FAULT
  } state_t;

  state_t state_q, state_d;

  logic [63:0]      pc_q, pc_d;
  logic [31:0]      instr_mem [FIFO_DEPTH];
  logic [63:0]      pc_mem    [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             fault_q;
  logic [63:0]      fault_pc_q;

  logic pop, can_push, bad_pc;
  logic do_push, do_flush, do_fault, do_fault_clr;

  assign Inst_Address    = pc_q;
  assign out_valid       = (count_q != '0);
  assign out_instruction = instr_mem[rd_ptr_q];
  assign out_pc          = pc_mem[rd_ptr_q];
  assign fault           = fault_q;
  assign fault_pc        = fault_pc_q;

  assign pop      = out_valid & out_ready;
  assign can_push = (count_q < DEPTH_C) | pop;
  assign bad_pc   = (pc_q[1:0] != 2'b00) | (pc_q > LAST_ADDR);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= RUN;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN: begin
        if (redirect_valid) state_d = RUN;
        else if (halt)      state_d = HALTED;
        else if (bad_pc)    state_d = FAULT;
      end
      // A redirect while halted still honours halt for the next state.
      HALTED:  if (!halt) state_d = RUN;
      FAULT:   if (redirect_valid) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    do_push      = 1'b0;
    do_flush     = 1'b0;
    do_fault     = 1'b0;
    do_fault_clr = 1'b0;
    pc_d         = pc_q;
    unique case (state_q)
      RUN: begin
        if (redirect_valid) begin
          do_flush = 1'b1;
          pc_d     = redirect_pc;
        end else if (halt) begin
          do_push = 1'b0;
        end else if (bad_pc) begin
          do_fault = 1'b1;
        end else if (can_push) begin
          do_push = 1'b1;
          pc_d    = pc_q + 64'd4;
        end
      end
      HALTED: begin
        if (redirect_valid) begin
          do_flush = 1'b1;
          pc_d     = redirect_pc;
        end
      end
      FAULT: begin
        if (redirect_valid) begin
          do_flush     = 1'b1;
          do_fault_clr = 1'b1;
          pc_d         = redirect_pc;
        end
      end
      default: pc_d = pc_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q       <= RESET_PC;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      fault_q    <= 1'b0;
      fault_pc_q <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        instr_mem[i] <= '0;
        pc_mem[i]    <= '0;
      end
    end else begin
      pc_q <= pc_d;
      if (do_fault) begin
        fault_q    <= 1'b1;
        fault_pc_q <= pc_q;
      end else if (do_fault_clr) begin
        fault_q <= 1'b0;
      end
      if (do_push) begin
        instr_mem[wr_ptr_q] <= Instruction;
        pc_mem[wr_ptr_q]    <= pc_q;
      end
      // Flush overrides a same-cycle pop; that entry was still taken by decode.
      if (do_flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
        unique case ({do_push, pop})
          2'b10:   count_q <= count_q + CNT_W'(1);
          2'b01:   count_q <= count_q - CNT_W'(1);
          default: count_q <= count_q;
        endcase
      end
    end
  end

`ifdef FETCH_PERF_EN
  logic stalled;
  assign stalled = (state_q == RUN) & ~redirect_valid & ~halt & ~bad_pc & ~can_push;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_fetched <= '0;
      perf_stalled <= '0;
    end else begin
      if (do_push && (perf_fetched != '1)) perf_fetched <= perf_fetched + 32'd1;
      if (stalled && (perf_stalled != '1)) perf_stalled <= perf_stalled + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: expected {pc, word} entries are queued as stimulus is
// driven and compared whenever decode accepts the FIFO head.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] Inst_Address;
  logic [31:0] Instruction;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        halt;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instruction;
  logic [63:0] out_pc;
  logic        fault;
  logic [63:0] fault_pc;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_stalled;
`endif

  int unsigned  checks = 0;
  int unsigned  errors = 0;
  logic [95:0]  exp_q[$];

  fetch_sequencer #(
    .RESET_PC  (64'd0),
    .MEM_BYTES (16),
    .FIFO_DEPTH(2)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .Inst_Address   (Inst_Address),
    .Instruction    (Instruction),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt           (halt),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instruction(out_instruction),
    .out_pc         (out_pc),
    .fault          (fault),
    .fault_pc       (fault_pc)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_stalled   (perf_stalled)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word_at(input logic [63:0] a);
    case (a)
      64'd0:   return 32'h02853483;
      64'd4:   return 32'h009A84B3;
      64'd8:   return 32'h00148493;
      64'd12:  return 32'h02953423;
      default: return 32'hDEADBEEF;
    endcase
  endfunction

  always_comb Instruction = word_at(Inst_Address);

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic expect_pc(input logic [63:0] pc);
    exp_q.push_back({pc, word_at(pc)});
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pop", out_pc, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        logic [95:0] e;
        e = exp_q.pop_front();
        check("out_pc", out_pc, e[95:32]);
        check("out_instr", {32'd0, out_instruction}, {32'd0, e[31:0]});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    halt           = 1'b0;
    out_ready      = 1'b1;
    #12;
    check("rst_valid", {63'd0, out_valid}, 64'd0);
    check("rst_addr", Inst_Address, 64'd0);
    check("rst_out_pc", out_pc, 64'd0);
    check("rst_out_instr", {32'd0, out_instruction}, 64'd0);
    check("rst_fault", {63'd0, fault}, 64'd0);
    check("rst_fault_pc", fault_pc, 64'd0);

    // Sequential fetch to the end of memory, then fault at 16.
    @(posedge clk); #1;
    reset = 1'b1;
    expect_pc(0); expect_pc(4); expect_pc(8); expect_pc(12);
    step(5);
    check("seq_drained", 64'(exp_q.size()), 64'd0);
    check("seq_fault", {63'd0, fault}, 64'd1);
    check("seq_fault_pc", fault_pc, 64'd16);
    check("seq_addr_hold", Inst_Address, 64'd16);
    check("seq_no_valid", {63'd0, out_valid}, 64'd0);

    // Backpressure fills the FIFO at pc 0,4 and holds the address at 8.
    out_ready      = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 64'd0;
    step(1);
    redirect_valid = 1'b0;
    check("bp_fault_clr", {63'd0, fault}, 64'd0);
    step(5);
    check("bp_addr_hold", Inst_Address, 64'd8);
    check("bp_valid", {63'd0, out_valid}, 64'd1);
    check("bp_head_pc", out_pc, 64'd0);
    check("bp_head_instr", {32'd0, out_instruction}, 64'h02853483);
    expect_pc(0); expect_pc(4); expect_pc(8); expect_pc(12);
    out_ready = 1'b1;
    step(6);
    check("bp_drained", 64'(exp_q.size()), 64'd0);
    check("bp_fault_pc", fault_pc, 64'd16);

    // Redirect to 4 while pc=12 with two entries buffered.
    out_ready      = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 64'd4;
    step(1);
    redirect_valid = 1'b0;
    step(2);
    check("rd_pre_addr", Inst_Address, 64'd12);
    check("rd_pre_valid", {63'd0, out_valid}, 64'd1);
    redirect_valid = 1'b1;
    redirect_pc    = 64'd4;
    step(1);
    redirect_valid = 1'b0;
    check("rd_flushed", {63'd0, out_valid}, 64'd0);
    check("rd_addr", Inst_Address, 64'd4);
    expect_pc(4); expect_pc(8); expect_pc(12);
    out_ready = 1'b1;
    step(1);
    check("rd_latency_valid", {63'd0, out_valid}, 64'd1);
    step(5);
    check("rd_drained", 64'(exp_q.size()), 64'd0);
    check("rd_fault", {63'd0, fault}, 64'd1);

    // Misaligned redirect faults without pushing; redirect to 0 recovers.
    redirect_valid = 1'b1;
    redirect_pc    = 64'd6;
    step(1);
    redirect_valid = 1'b0;
    check("mis_fault_clr", {63'd0, fault}, 64'd0);
    check("mis_addr", Inst_Address, 64'd6);
    step(1);
    check("mis_fault", {63'd0, fault}, 64'd1);
    check("mis_fault_pc", fault_pc, 64'd6);
    check("mis_no_push", {63'd0, out_valid}, 64'd0);
    out_ready      = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 64'd0;
    step(1);
    redirect_valid = 1'b0;
    check("rec_fault", {63'd0, fault}, 64'd0);
    check("rec_fault_pc_hold", fault_pc, 64'd6);

    // Halt at pc=8: address freezes and the FIFO drains.
    step(2);
    halt = 1'b1;
    step(1);
    check("halt_addr", Inst_Address, 64'd8);
    expect_pc(0); expect_pc(4); expect_pc(8); expect_pc(12);
    out_ready = 1'b1;
    step(3);
    check("halt_empty", {63'd0, out_valid}, 64'd0);
    check("halt_addr_hold", Inst_Address, 64'd8);
    check("halt_consumed", 64'(exp_q.size()), 64'd2);
    halt = 1'b0;
    step(1);
    check("resume_no_push", {63'd0, out_valid}, 64'd0);
    step(1);
    check("resume_valid", {63'd0, out_valid}, 64'd1);
    check("resume_pc", out_pc, 64'd8);

    // Asynchronous reset between edges discards the stream at once.
    #2;
    exp_q.delete();
    reset = 1'b0;
    #1;
    check("arst_valid", {63'd0, out_valid}, 64'd0);
    check("arst_addr", Inst_Address, 64'd0);
    check("arst_out_pc", out_pc, 64'd0);
    check("arst_fault", {63'd0, fault}, 64'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    expect_pc(0); expect_pc(4); expect_pc(8); expect_pc(12);
    step(6);
    check("post_rst_drained", 64'(exp_q.size()), 64'd0);
    check("post_rst_fault_pc", fault_pc, 64'd16);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
